sp_ram_arbiter: RTL and testbench

//  Two-master front end for one sp_ram instance (e.g. core instr port + debug/data port).

---
 rtl/sp_ram_arbiter_if.sv | 23 ++
 rtl/sp_ram_arbiter.sv | 72 +++++++
 tb/tb_sp_ram_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_arbiter_if.sv
// One master's req/gnt/rvalid bus toward the sp_ram arbiter.
interface sp_ram_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                    req;
  logic                    gnt;
  logic                    rvalid;
  logic [31:0]             addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Round-robin two-master front end for a single sp_ram port with 1-cycle read latency.
module sp_ram_arbiter #(
  parameter  int unsigned ADDR_WIDTH = 12,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned BE_W       = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sp_ram_arbiter_if.slave       m0,
  sp_ram_arbiter_if.slave       m1,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [BE_W-1:0]       ram_be_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  logic                  r_last;
  logic [1:0]            r_rsp;
  logic [DATA_WIDTH-1:0] r_rdata_hold [2];
  logic [1:0]            w_gnt;
  logic                  w_unused_addr;

  // On contention the master that was not granted last wins.
  always_comb begin
    w_gnt    = 2'b00;
    w_gnt[0] = m0.req & (~m1.req | r_last);
    w_gnt[1] = m1.req & (~m0.req | ~r_last);
  end

  assign m0.gnt = w_gnt[0];
  assign m1.gnt = w_gnt[1];

  // Idle cycles present m0's bus with en/we low; reset also blocks any RAM access.
  always_comb begin
    ram_en_o    = (|w_gnt) & rst_n;
    ram_addr_o  = m0.addr[ADDR_WIDTH-1:0];
    ram_we_o    = m0.we;
    ram_be_o    = m0.be;
    ram_wdata_o = m0.wdata;
    if (w_gnt[1]) begin
      ram_addr_o  = m1.addr[ADDR_WIDTH-1:0];
      ram_we_o    = m1.we;
      ram_be_o    = m1.be;
      ram_wdata_o = m1.wdata;
    end
    ram_we_o = ram_we_o & ram_en_o;
  end

  assign w_unused_addr = ^{m0.addr[31:ADDR_WIDTH], m1.addr[31:ADDR_WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last          <= 1'b1;
      r_rsp           <= 2'b00;
      r_rdata_hold[0] <= '0;
      r_rdata_hold[1] <= '0;
    end else begin
      r_rsp <= w_gnt;
      if (|w_gnt) r_last <= w_gnt[1];
      if (r_rsp[0]) r_rdata_hold[0] <= ram_rdata_i;
      if (r_rsp[1]) r_rdata_hold[1] <= ram_rdata_i;
    end
  end

  assign m0.rvalid = r_rsp[0];
  assign m1.rvalid = r_rsp[1];
  assign m0.rdata  = r_rsp[0] ? ram_rdata_i : r_rdata_hold[0];
  assign m1.rdata  = r_rsp[1] ? ram_rdata_i : r_rdata_hold[1];

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural 1-cycle-latency byte-enabled RAM.
module tb_sp_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_en;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mem [1024];

  int checks = 0;
  int errors = 0;

  sp_ram_arbiter_if #(.DATA_WIDTH(32)) m0_if ();
  sp_ram_arbiter_if #(.DATA_WIDTH(32)) m1_if ();

  sp_ram_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0          (m0_if),
    .m1          (m1_if),
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 8) ? 32'h1234_5678 : (32'hA5A5_0000 | i);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      ram_rdata <= '0;
    end else if (ram_en) begin
      ram_rdata <= mem[ram_addr[11:2]];
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m0_if.req = 0; m0_if.addr = '0; m0_if.we = 0; m0_if.be = 4'hF; m0_if.wdata = '0;
    m1_if.req = 0; m1_if.addr = '0; m1_if.we = 0; m1_if.be = 4'hF; m1_if.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", ram_en, 0);
    chk("rst_rvalid0", m0_if.rvalid, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_gnt0", m0_if.gnt, 0);
    chk("idle_gnt1", m1_if.gnt, 0);
    chk("idle_rvalid0", m0_if.rvalid, 0);
    chk("idle_rvalid1", m1_if.rvalid, 0);
    chk("idle_en", ram_en, 0);
    chk("idle_we", ram_we, 0);
    chk("idle_rdata0", m0_if.rdata, 0);
    chk("idle_rdata1", m1_if.rdata, 0);

    // m0 single read of word 1
    step();
    m0_if.req = 1; m0_if.addr = 32'h004;
    #1;
    chk("rd_gnt0", m0_if.gnt, 1);
    chk("rd_gnt1", m1_if.gnt, 0);
    chk("rd_en", ram_en, 1);
    chk("rd_addr", ram_addr, 12'h004);
    chk("rd_rvalid_early", m0_if.rvalid, 0);
    step();
    m0_if.req = 0;
    chk("rd_rvalid0", m0_if.rvalid, 1);
    chk("rd_rvalid1", m1_if.rvalid, 0);
    chk("rd_rdata0", m0_if.rdata, 32'hA5A5_0001);
    step();
    chk("rd_rvalid_drop", m0_if.rvalid, 0);
    chk("rd_hold0", m0_if.rdata, 32'hA5A5_0001);

    // m0 partial write then read back
    m0_if.req = 1; m0_if.we = 1; m0_if.addr = 32'h010; m0_if.be = 4'b0011;
    m0_if.wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_we", ram_we, 1);
    chk("wr_be", ram_be, 4'b0011);
    chk("wr_wdata", ram_wdata, 32'hDEAD_BEEF);
    step();
    chk("wr_rvalid", m0_if.rvalid, 1);
    m0_if.we = 0; m0_if.be = 4'hF;
    step();
    m0_if.req = 0;
    chk("wr_rb_rvalid", m0_if.rvalid, 1);
    chk("wr_rb_rdata", m0_if.rdata, 32'hA5A5_BEEF);

    // m1 reads 0x020, then m0 streams while m1 data must stay put
    m1_if.req = 1; m1_if.addr = 32'h020;
    #1;
    chk("m1_gnt", m1_if.gnt, 1);
    step();
    m1_if.req = 0;
    chk("m1_rvalid", m1_if.rvalid, 1);
    chk("m1_rdata", m1_if.rdata, 32'h1234_5678);
    for (int k = 0; k < 4; k++) begin
      m0_if.req = 1; m0_if.addr = 32'(4 * k);
      #1;
      chk("str_gnt0", m0_if.gnt, 1);
      chk("str_m1_hold_pre", m1_if.rdata, 32'h1234_5678);
      step();
      chk("str_rvalid0", m0_if.rvalid, 1);
      chk("str_rdata0", m0_if.rdata, init_word(k));
      chk("str_rvalid1", m1_if.rvalid, 0);
      chk("str_m1_hold", m1_if.rdata, 32'h1234_5678);
    end
    m0_if.req = 0;

    // m1-only grant so m0 wins the next contest
    m1_if.req = 1;
    step();
    m1_if.req = 0;
    chk("m1b_rvalid", m1_if.rvalid, 1);

    // both request for 6 cycles: m0,m1,m0,m1,m0,m1
    m0_if.req = 1; m0_if.addr = 32'h004;
    m1_if.req = 1; m1_if.addr = 32'h020;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_gnt0", m0_if.gnt, (i % 2 == 0) ? 1 : 0);
      chk("rr_gnt1", m1_if.gnt, (i % 2 == 1) ? 1 : 0);
      if (i > 0) begin
        chk("rr_rvalid0", m0_if.rvalid, (i % 2 == 1) ? 1 : 0);
        chk("rr_rvalid1", m1_if.rvalid, (i % 2 == 0) ? 1 : 0);
        chk("rr_rdata0", m0_if.rdata, 32'hA5A5_0001);
        chk("rr_rdata1", m1_if.rdata, 32'h1234_5678);
      end
      step();
    end
    m0_if.req = 0; m1_if.req = 0;
    chk("rr_last_rvalid0", m0_if.rvalid, 0);
    chk("rr_last_rvalid1", m1_if.rvalid, 1);
    step();
    chk("rr_tail_rvalid1", m1_if.rvalid, 0);

    // m0 granted (last=m0), then reset lands during the next m0 grant
    m0_if.req = 1; m0_if.addr = 32'h004;
    step();
    chk("pre_rst_rvalid0", m0_if.rvalid, 1);
    #1;
    chk("rstg_gnt0", m0_if.gnt, 1);
    rst_n = 1'b0;
    #1;
    chk("rstg_gnt_comb", m0_if.gnt, 1);
    chk("rstg_en", ram_en, 0);
    chk("rstg_we", ram_we, 0);
    chk("rstg_rdata0", m0_if.rdata, 0);
    step();
    m0_if.req = 0;
    chk("rst_rvalid0_lost", m0_if.rvalid, 0);
    chk("rst_en_hold", ram_en, 0);
    step();
    chk("rst_rvalid0_still", m0_if.rvalid, 0);
    rst_n = 1'b1;
    m0_if.req = 1; m1_if.req = 1;
    #1;
    chk("post_rst_gnt0", m0_if.gnt, 1);
    chk("post_rst_gnt1", m1_if.gnt, 0);
    step();
    m0_if.req = 0; m1_if.req = 0;
    chk("post_rst_rvalid0", m0_if.rvalid, 1);
    chk("post_rst_rdata0", m0_if.rdata, 32'hA5A5_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
